// File: rtl/shift_decode_sequencer.sv
// shift_decode_sequencer
// Sequences the 3-bit shift-and-decode datapath.
// A start command loads a seed operand. The block then emits `count` results
// on a valid/ready stream. Each result is the code (a >> SHIFT) and its
// one-hot class. After each accepted result the operand steps by one (mod 8).
// Codes 4..7 fall outside the covered decode set. They produce an all-zero
// class and set the sticky err_uncov flag when they are transferred.
// Optional build macro: DECODE_ASSERT_EN adds a simulation-only check that
// reports every transfer of an uncovered code. Synthesised logic is unchanged.

module shift_decode_sequencer #(
    parameter int SHIFT = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       seed,
    input  logic [CNT_W-1:0] count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       out_code,
    output logic [3:0]       out_class,
    output logic             err_uncov,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       a;
    logic [CNT_W-1:0] remaining;

    logic             xfer;
    logic [2:0]       load_operand;
    logic [2:0]       load_code;
    logic [3:0]       load_class;

    // One-hot class of a code; codes 4..7 are deliberately left uncovered
    function automatic logic [3:0] decode(input logic [2:0] code);
        logic [3:0] cls;
        unique case (code)
            3'd0:    cls = 4'b0001;
            3'd1:    cls = 4'b0010;
            3'd2:    cls = 4'b0100;
            3'd3:    cls = 4'b1000;
            default: cls = 4'b0000;
        endcase
        return cls;
    endfunction

    assign xfer = out_valid && out_ready;

    // Decode the operand that becomes current on the next edge: the seed
    // when launching from IDLE, otherwise the incremented operand
    always_comb begin
        load_operand = (state == IDLE) ? seed : 3'(a + 3'd1);
        load_code    = 3'(load_operand >> SHIFT);
        load_class   = decode(load_code);
    end

`ifdef DECODE_ASSERT_EN
    // Report each transfer of an uncovered code; simulation carries on
    always @(posedge clk) begin
        if (rst_n && xfer) begin
            assert (out_code < 3'd4)
            else $error("uncovered decode code %0d transferred at time %0t", out_code, $time);
        end
    end
`else
`endif

    // Sequencer FSM: the state, the operand, the step counter and every output
    // are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= 3'd0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_code  <= 3'd0;
            out_class <= 4'd0;
            err_uncov <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a         <= seed;
                        remaining <= count;
                        err_uncov <= 1'b0;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_code  <= load_code;
                            out_class <= load_class;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        a         <= 3'(a + 3'd1);
                        remaining <= remaining - CNT_W'(1);
                        if (out_code[2]) begin
                            err_uncov <= 1'b1;
                        end
                        if (remaining == CNT_W'(1)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_code  <= 3'd0;
                            out_class <= 4'd0;
                        end else begin
                            out_code  <= load_code;
                            out_class <= load_class;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_code  <= 3'd0;
                    out_class <= 4'd0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_decode_sequencer.sv
// tb_shift_decode_sequencer
// Drives two sequencers from the same stimulus. One is built with SHIFT=0 and
// the other with SHIFT=1. A queue-based model holds the operands that are
// still to be emitted. On every falling edge both instances are compared with
// that model. Directed commands pin the model with hand-computed code
// sequences. Randomized commands, random backpressure and stray start pulses
// follow.

module tb_shift_decode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [2:0] seed = 3'd0;
    logic [3:0] count = 4'd0;
    logic       out_ready = 1'b1;

    logic       valid_o [2];
    logic [2:0] code_o  [2];
    logic [3:0] class_o [2];
    logic       err_o   [2];
    logic       busy_o  [2];
    logic       done_o  [2];

    int total = 0;
    int bad   = 0;

    // Reference model: operands still to be emitted, pending done, sticky errors
    int sh [2] = '{0, 1};
    int op_q [$];
    bit m_done = 1'b0;
    bit m_err [2] = '{1'b0, 1'b0};

    // Observed transfers and per-command counters
    int obs0 [$];
    int obs1 [$];
    int want [$];
    int done_cnt  [2] = '{0, 0};
    int valid_cnt [2] = '{0, 0};
    int busy_cnt  [2] = '{0, 0};

    shift_decode_sequencer #(.SHIFT(0), .CNT_W(4)) dut_s0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .count     (count),
        .out_ready (out_ready),
        .out_valid (valid_o[0]),
        .out_code  (code_o[0]),
        .out_class (class_o[0]),
        .err_uncov (err_o[0]),
        .busy      (busy_o[0]),
        .done      (done_o[0])
    );

    shift_decode_sequencer #(.SHIFT(1), .CNT_W(4)) dut_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .count     (count),
        .out_ready (out_ready),
        .out_valid (valid_o[1]),
        .out_code  (code_o[1]),
        .out_class (class_o[1]),
        .err_uncov (err_o[1]),
        .busy      (busy_o[1]),
        .done      (done_o[1])
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    function automatic void check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    function automatic void check_codes(input string name, input int k);
        int got [$];
        if (k == 0) got = obs0;
        else        got = obs1;
        check_output($sformatf("%s_len", name), got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            check_output($sformatf("%s_code%0d", name, i), got[i], want[i]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_obs();
        obs0.delete();
        obs1.delete();
        for (int k = 0; k < 2; k++) begin
            done_cnt[k]  = 0;
            valid_cnt[k] = 0;
            busy_cnt[k]  = 0;
        end
    endfunction

    // Model step: uses the inputs as they stood just before each rising edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            op_q.delete();
            m_done   = 1'b0;
            m_err[0] = 1'b0;
            m_err[1] = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (op_q.size() > 0) begin
            if (out_ready) begin
                for (int k = 0; k < 2; k++) begin
                    if ((op_q[0] >> sh[k]) >= 4) m_err[k] = 1'b1;
                end
                void'(op_q.pop_front());
                if (op_q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            m_err[0] = 1'b0;
            m_err[1] = 1'b0;
            for (int i = 0; i < int'(count); i++) begin
                op_q.push_back((int'(seed) + i) % 8);
            end
            if (count == 4'd0) m_done = 1'b1;
        end
    end

    // Compare both instances against the model on every falling edge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int ev;
            int ec;
            int ecl;
            ev  = (op_q.size() > 0) ? 1 : 0;
            ec  = (ev != 0) ? (op_q[0] >> sh[k]) : 0;
            ecl = (ev != 0 && ec < 4) ? (1 << ec) : 0;
            check_output($sformatf("valid[%0d]", k), int'(valid_o[k]), ev);
            check_output($sformatf("code[%0d]", k),  int'(code_o[k]),  ec);
            check_output($sformatf("class[%0d]", k), int'(class_o[k]), ecl);
            check_output($sformatf("busy[%0d]", k),  int'(busy_o[k]),  (ev != 0 || m_done) ? 1 : 0);
            check_output($sformatf("done[%0d]", k),  int'(done_o[k]),  m_done ? 1 : 0);
            check_output($sformatf("err[%0d]", k),   int'(err_o[k]),   m_err[k] ? 1 : 0);
            if (valid_o[k] && out_ready) begin
                if (k == 0) obs0.push_back(int'(code_o[0]));
                else        obs1.push_back(int'(code_o[1]));
            end
            if (done_o[k])  done_cnt[k]++;
            if (valid_o[k]) valid_cnt[k]++;
            if (busy_o[k])  busy_cnt[k]++;
        end
    end

    // Issue one command, then run until the model is idle again.
    // mode 0: always ready; 1: random ready; 2: three stall cycles per item.
    // poke: pulse start with different operands while the command is running.
    task automatic apply_stimulus(input logic [2:0] s, input int c, input int mode, input bit poke);
        int cyc;
        int stall;
        clear_obs();
        seed      = s;
        count     = 4'(c);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        stall = 0;
        while (op_q.size() > 0 || m_done) begin
            if (cyc >= 200) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout: command seed=%0d count=%0d did not finish", s, c);
                break;
            end
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = ((stall % 4) == 3);
                default: out_ready = 1'b1;
            endcase
            stall++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                seed  = 3'(s + 3'd2);
                count = 4'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        check_output("rst_valid", int'(valid_o[1]), 0);
        check_output("rst_code",  int'(code_o[1]),  0);
        check_output("rst_class", int'(class_o[1]), 0);
        check_output("rst_busy",  int'(busy_o[1]),  0);
        check_output("rst_done",  int'(done_o[1]),  0);
        check_output("rst_err",   int'(err_o[0]),   0);
        rst_n = 1'b1;
        tick();

        $display("[TB] seed=1 count=8, always ready");
        want = {0, 1, 1, 2, 2, 3, 3, 0};
        apply_stimulus(3'd1, 8, 0, 1'b0);
        check_codes("seq8", 1);
        check_output("seq8_valid_cycles", valid_cnt[1], 8);
        check_output("seq8_done_pulses",  done_cnt[1], 1);
        check_output("seq8_err_s1", int'(err_o[1]), 0);
        check_output("seq8_err_s0", int'(err_o[0]), 1);

        $display("[TB] backpressure seed=4 count=3");
        want = {2, 2, 3};
        apply_stimulus(3'd4, 3, 2, 1'b0);
        check_codes("stall", 1);
        check_output("stall_valid_cycles", valid_cnt[1], 12);
        check_output("stall_done_pulses",  done_cnt[1], 1);

        $display("[TB] count=0 seed=5");
        apply_stimulus(3'd5, 0, 0, 1'b0);
        check_output("zero_valid_cycles", valid_cnt[1], 0);
        check_output("zero_done_pulses",  done_cnt[1], 1);
        check_output("zero_busy_cycles",  busy_cnt[1], 1);

        $display("[TB] SHIFT=0 seed=3 count=2");
        want = {3, 4};
        apply_stimulus(3'd3, 2, 0, 1'b0);
        check_codes("uncov", 0);
        check_output("uncov_err_s0", int'(err_o[0]), 1);
        check_output("uncov_err_s1", int'(err_o[1]), 0);
        repeat (3) tick();
        check_output("uncov_err_sticky", int'(err_o[0]), 1);
        apply_stimulus(3'd0, 1, 0, 1'b0);
        check_output("uncov_err_cleared", int'(err_o[0]), 0);

        $display("[TB] start pulse while busy, seed=7");
        want = {3, 0, 0, 1};
        apply_stimulus(3'd7, 4, 0, 1'b1);
        check_codes("poke", 1);
        check_output("poke_done_pulses", done_cnt[1], 1);

        $display("[TB] reset in the middle of a command");
        clear_obs();
        seed      = 3'd0;
        count     = 4'd8;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_output("midrst_xfers", obs1.size(), 2);
        check_output("midrst_valid", int'(valid_o[1]), 0);
        check_output("midrst_code",  int'(code_o[1]),  0);
        check_output("midrst_class", int'(class_o[1]), 0);
        check_output("midrst_busy",  int'(busy_o[1]),  0);
        check_output("midrst_done",  int'(done_o[1]),  0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("midrst_no_done", done_cnt[1], 0);
        want = {0, 0};
        apply_stimulus(3'd0, 2, 0, 1'b0);
        check_codes("after_rst", 1);

        $display("[TB] randomized commands");
        repeat (40) begin
            apply_stimulus(3'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 1,
                           1'($urandom_range(0, 1)));
            check_output("rand_done_pulses", done_cnt[1], 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_decode_sequencer.md
Name: shift_decode_sequencer

Overview:
Controller that sequences the 3-bit shift-and-decode datapath used across the procedural-block exercises.
- On a start command it loads a seed operand and steps it through a programmed number of increments.
- Each step computes code = a >> SHIFT and decodes it into a one-hot class.
- Each code/class result is presented on a valid/ready output stream.
- Codes outside the covered decode set are flagged, so incomplete case coverage is visible in hardware.

Parameters:
SHIFT, 1, right-shift amount applied to the operand (legal 0..2)
CNT_W, 4, width of the step-count input and remaining-step counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command pulse; sampled only in IDLE
seed  input  3  initial operand a, captured with start
count  input  CNT_W  number of results to emit; 0 is legal
out_ready  input  1  downstream ready
out_valid  output  1  result valid
out_code  output  3  a >> SHIFT for the current operand
out_class  output  4  one-hot decode of out_code
err_uncov  output  1  sticky: an uncovered code was emitted
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of a command

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n; all state is in one always_ff on clk/rst_n.
- Reset values:
  - state = IDLE
  - operand a = 0; remaining = 0
  - out_valid = 0, out_code = 0, out_class = 0
  - err_uncov = 0, busy = 0, done = 0
- Reset mid-command aborts immediately. No done pulse is produced. err_uncov clears.
- States: IDLE, EMIT, DONE.
- IDLE:
  - On start: a <= seed; remaining <= count; err_uncov <= 0.
  - If count == 0, go to DONE. Otherwise go to EMIT.
- EMIT:
  - out_valid = 1. out_code/out_class are derived from the registered a.
  - First out_valid is visible in the cycle after the start edge (1-cycle latency).
  - Transfer occurs when out_valid && out_ready at a rising edge. On transfer:
    - a <= a + 1, wrapping 7 -> 0 (mod-8, no carry).
    - remaining <= remaining - 1.
    - If remaining == 1, go to DONE; else stay in EMIT.
  - Back-to-back transfers are allowed, one per cycle.
  - While out_ready = 0, out_code, out_class and out_valid hold stable.
- DONE: done = 1 for exactly one cycle; busy = 1; next state IDLE.
- start outside IDLE is ignored, including start coincident with the final transfer.
- Decode, written as a unique case with every reachable branch explicit:
  - code 0 -> 4'b0001
  - code 1 -> 4'b0010
  - code 2 -> 4'b0100
  - code 3 -> 4'b1000
  - codes 4..7 -> 4'b0000 (explicit default branch)
- err_uncov:
  - Set on any transfer whose out_code is 4..7.
  - Holds until the next accepted start or reset.
  - With SHIFT >= 1 codes are always 0..3, so err_uncov never sets.
  - With SHIFT = 0 codes 4..7 are reachable.
- out_code width stays 3; upper bits are zero-filled by the shift.
- Outputs in IDLE: out_code = 0, out_class = 0.

Optional Feature:
Macro DECODE_ASSERT_EN.
- Defined: adds an immediate assertion in the decode block. It fires $error with the code value and simulation time on any transfer of an uncovered code (4..7). Simulation continues. err_uncov behaviour is unchanged.
- Undefined: no assertion. Only err_uncov reports the condition.
- Synthesised logic is identical either way.

Test Plan:
- SHIFT=1, seed=1, count=8, out_ready=1:
  - out_code sequence is 0,1,1,2,2,3,3,0 (a wraps 7->0).
  - out_class is 0001,0010,0010,0100,0100,1000,1000,0001.
  - Eight consecutive valid cycles, then done for 1 cycle, err_uncov=0.
- Backpressure, SHIFT=1, seed=4, count=3:
  - Hold out_ready=0 for 3 cycles on each item.
  - out_code 2,2,3 each held stable while stalled.
  - Exactly 3 transfers, then done.
- count=0, seed=5:
  - done asserts the cycle after start; out_valid never asserts; busy high for 1 cycle.
- SHIFT=0, seed=3, count=2:
  - codes 3 then 4; class 1000 then 0000.
  - err_uncov rises after the second transfer and stays high until the next start (DECODE_ASSERT_EN build: one $error).
- Reset mid-run, SHIFT=1, seed=0, count=8:
  - Assert rst_n=0 after 2 transfers.
  - All outputs go to 0 immediately, with no done pulse.
  - After release, a new start with seed=0, count=2 yields codes 0,0.
- Pulse start while busy, with seed=7:
  - Ignored; operand sequence continues unchanged and done count is 1.
